// File: rtl/vi_dcache_pkg.sv
// Shared types and constants for the Vi data-cache miss controller.
// DCACHE_WB_EN adds the writeback state for dirty victims.
package vi_dcache_pkg;

  localparam int ADDR_W      = 20;
  localparam int LINE_W      = 128;
  localparam int WAY_W       = 2;
  localparam int BEAT_W      = 32;
  localparam int OFFSET_W    = 4;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int CNT_W       = $clog2(BEATS);
  localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;

  typedef logic [CNT_W-1:0] beat_t;

  localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef DCACHE_WB_EN
    S_WB    = 3'd1,
`endif
    S_FILL  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dcache_miss_ctrl_if.sv
// Beat-level req/ack memory port between the miss controller and the memory side.
interface dcache_miss_ctrl_if;
  import vi_dcache_pkg::*;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [BEAT_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [BEAT_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );

endinterface

// File: rtl/dcache_miss_ctrl_line_buffer.sv
// Line register: holds the victim line for writeback, then assembles the refill beat by beat.
module dcache_line_buffer
  import vi_dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              load_i,
  input  logic [LINE_W-1:0] load_data_i,
  input  logic              wr_en_i,
  input  beat_t             wr_beat_i,
  input  logic [BEAT_W-1:0] wr_data_i,
  output logic [LINE_W-1:0] line_o
);

  logic [LINE_W-1:0] line_q;

  // A whole-line load wins over a beat write; the two never coincide in practice.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= load_data_i;
    end else if (wr_en_i) begin
      line_q[BEAT_W*wr_beat_i +: BEAT_W] <= wr_data_i;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: stalls the core, optionally writes back the victim, refills the line.
// Define DCACHE_WB_EN for writeback caches; otherwise every miss goes straight to the fill.
module dcache_miss_ctrl
  import vi_dcache_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic                   c_miss_i,
  input  logic [ADDR_W-1:0]      c_addr_i,
  input  logic [WAY_W-1:0]       c_lru_way_i,
  input  logic                   kill_i,
  input  logic                   victim_dirty_i,
  input  logic [LINE_ADDR_W-1:0] victim_addr_i,
  input  logic [LINE_W-1:0]      victim_data_i,
  dcache_miss_ctrl_if.master     mem,
  output logic                   fill_we_o,
  output logic [WAY_W-1:0]       fill_way_o,
  output logic [LINE_ADDR_W-1:0] fill_addr_o,
  output logic [LINE_W-1:0]      fill_data_o,
  output logic                   refill_done_o,
  output logic                   stall_core_o
);

  state_t                 state_q, state_d;
  beat_t                  beat_q, beat_d;
  logic                   req_q, req_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [BEAT_W-1:0]      wdata_q, wdata_d;
  logic                   fill_we_q, fill_we_d;
  logic                   done_q, done_d;
  logic [WAY_W-1:0]       way_q;
  logic [LINE_ADDR_W-1:0] line_addr_q;
  logic                   cap_en, buf_load, buf_wr, stall;
  logic [LINE_W-1:0]      line;
`ifdef DCACHE_WB_EN
  logic [LINE_ADDR_W-1:0] vaddr_q;
`endif

  dcache_line_buffer u_line_buffer (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .load_i      (buf_load),
    .load_data_i (victim_data_i),
    .wr_en_i     (buf_wr),
    .wr_beat_i   (beat_q),
    .wr_data_i   (mem.mem_rdata_i),
    .line_o      (line)
  );

  // Each beat: raise req with stable addr/data, drop it on ack, re-raise next cycle for the next beat.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    fill_we_d = 1'b0;
    done_d    = 1'b0;
    cap_en    = 1'b0;
    buf_load  = 1'b0;
    buf_wr    = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (c_miss_i && !kill_i) begin
          stall   = 1'b1;
          cap_en  = 1'b1;
          beat_d  = '0;
          req_d   = 1'b1;
          state_d = S_FILL;
          we_d    = 1'b0;
          addr_d  = {c_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
`ifdef DCACHE_WB_EN
          if (victim_dirty_i) begin
            state_d  = S_WB;
            buf_load = 1'b1;
            we_d     = 1'b1;
            addr_d   = {victim_addr_i, {OFFSET_W{1'b0}}};
            wdata_d  = victim_data_i[BEAT_W-1:0];
          end
`endif
        end
      end
`ifdef DCACHE_WB_EN
      S_WB: begin
        stall = 1'b1;
        if (req_q) begin
          if (mem.mem_ack_i) begin
            req_d  = 1'b0;
            beat_d = beat_q + beat_t'(1);
            if (beat_q == LAST_BEAT) begin
              state_d = S_FILL;
              we_d    = 1'b0;
            end
          end
        end else begin
          req_d   = 1'b1;
          addr_d  = {vaddr_q, beat_q, 2'b00};
          wdata_d = line[BEAT_W*beat_q +: BEAT_W];
        end
      end
`endif
      S_FILL: begin
        stall = 1'b1;
        if (req_q) begin
          if (mem.mem_ack_i) begin
            req_d  = 1'b0;
            buf_wr = 1'b1;
            beat_d = beat_q + beat_t'(1);
            if (beat_q == LAST_BEAT) begin
              state_d   = S_WRITE;
              fill_we_d = 1'b1;
            end
          end
        end else begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = {line_addr_q, beat_q, 2'b00};
        end
      end
      S_WRITE: begin
        stall   = 1'b1;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fill_we_q   <= 1'b0;
      done_q      <= 1'b0;
      way_q       <= '0;
      line_addr_q <= '0;
`ifdef DCACHE_WB_EN
      vaddr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      fill_we_q <= fill_we_d;
      done_q    <= done_d;
      if (cap_en) begin
        way_q       <= c_lru_way_i;
        line_addr_q <= c_addr_i[ADDR_W-1:OFFSET_W];
`ifdef DCACHE_WB_EN
        vaddr_q     <= victim_addr_i;
`endif
      end
    end
  end

  assign mem.mem_req_o   = req_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign fill_we_o       = fill_we_q;
  assign fill_way_o      = way_q;
  assign fill_addr_o     = line_addr_q;
  assign fill_data_o     = line;
  assign refill_done_o   = done_q;
  assign stall_core_o    = stall;

  logic unused_offset;
  assign unused_offset = ^c_addr_i[OFFSET_W-1:0];

`ifdef DCACHE_WB_EN
  assign mem.mem_we_o = we_q;
`else
  // Write-through build: no write beats ever leave this block.
  assign mem.mem_we_o = 1'b0;
  logic unused_wb;
  assign unused_wb = ^{we_q, victim_dirty_i, victim_addr_i};
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Self-checking bench for dcache_miss_ctrl; builds with or without DCACHE_WB_EN.
module tb_dcache_miss_ctrl;
  import vi_dcache_pkg::*;

`ifdef DCACHE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] wdata;
  } beat_s;

  logic                   clk_i = 1'b0;
  logic                   rsn_i = 1'b0;
  logic                   c_miss_i = 1'b0;
  logic [ADDR_W-1:0]      c_addr_i = '0;
  logic [WAY_W-1:0]       c_lru_way_i = '0;
  logic                   kill_i = 1'b0;
  logic                   victim_dirty_i = 1'b0;
  logic [LINE_ADDR_W-1:0] victim_addr_i = '0;
  logic [LINE_W-1:0]      victim_data_i = '0;
  logic                   fill_we_o;
  logic [WAY_W-1:0]       fill_way_o;
  logic [LINE_ADDR_W-1:0] fill_addr_o;
  logic [LINE_W-1:0]      fill_data_o;
  logic                   refill_done_o;
  logic                   stall_core_o;

  int n_cmp = 0;
  int n_err = 0;
  beat_s exp_q[$];

  dcache_miss_ctrl_if mem_bus ();

  dcache_miss_ctrl dut (
    .clk_i          (clk_i),
    .rsn_i          (rsn_i),
    .c_miss_i       (c_miss_i),
    .c_addr_i       (c_addr_i),
    .c_lru_way_i    (c_lru_way_i),
    .kill_i         (kill_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_addr_i  (victim_addr_i),
    .victim_data_i  (victim_data_i),
    .mem            (mem_bus),
    .fill_we_o      (fill_we_o),
    .fill_way_o     (fill_way_o),
    .fill_addr_o    (fill_addr_o),
    .fill_data_o    (fill_data_o),
    .refill_done_o  (refill_done_o),
    .stall_core_o   (stall_core_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete miss: model expectations from the rules, then play memory and watch every cycle.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [WAY_W-1:0] way,
                               input logic dirty, input logic [LINE_ADDR_W-1:0] vaddr,
                               input logic [LINE_W-1:0] vdata, input int lat, input int kill_at,
                               input bit hold);
    beat_s             b;
    logic [BEAT_W-1:0] rd_words[BEATS];
    logic [LINE_W-1:0] exp_line;
    int                wb_beats, exp_fill, fill_cyc, done_cyc, nfill, rd_n, age;
    bit                hs_ok, stall_ok, prev_req, prev_ack;
    logic              s_req, s_we, s_fwe, s_done, s_stall, ack;
    logic [ADDR_W-1:0] s_addr, prev_addr;
    logic [BEAT_W-1:0] s_wdata, prev_wdata, rdata;
    logic              prev_we;

    exp_q.delete();
    wb_beats = (dirty && WB_EN) ? BEATS : 0;
    for (int k = 0; k < wb_beats; k++) begin
      b.we    = 1'b1;
      b.addr  = ADDR_W'({vaddr, 4'h0}) + ADDR_W'(4 * k);
      b.wdata = BEAT_W'(vdata >> (32 * k));
      exp_q.push_back(b);
    end
    for (int k = 0; k < BEATS; k++) begin
      rd_words[k] = $urandom;
      exp_line[32*k +: 32] = rd_words[k];
      b.we    = 1'b0;
      b.addr  = (addr & ~ADDR_W'(15)) + ADDR_W'(4 * k);
      b.wdata = '0;
      exp_q.push_back(b);
    end
    exp_fill = ((wb_beats > 0) ? 2 : 1) * BEATS * (lat + 2);

    @(negedge clk_i);
    checkOutput("idle_req", mem_bus.mem_req_o, 0);
    c_miss_i = 1'b1; kill_i = 1'b0; c_addr_i = addr; c_lru_way_i = way;
    victim_dirty_i = dirty; victim_addr_i = vaddr; victim_data_i = vdata;
    #1 checkOutput("detect_stall", stall_core_o, 1);
    @(posedge clk_i);

    age = 0; rd_n = 0; nfill = 0; fill_cyc = -1; done_cyc = -1;
    hs_ok = 1'b1; stall_ok = 1'b1; prev_req = 1'b0; prev_ack = 1'b0;
    prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;
    for (int n = 1; n <= 300 && done_cyc < 0; n++) begin
      @(negedge clk_i);
      s_req = mem_bus.mem_req_o; s_we = mem_bus.mem_we_o; s_addr = mem_bus.mem_addr_o;
      s_wdata = mem_bus.mem_wdata_o; s_fwe = fill_we_o; s_done = refill_done_o; s_stall = stall_core_o;
      if (!hold) c_miss_i = 1'b0;
      kill_i = (n == kill_at);
      ack = 1'b0; rdata = $urandom;
      if (s_req) begin
        if (prev_ack) hs_ok = 1'b0;
        if (prev_req && !prev_ack && ({s_we, s_addr, s_wdata} != {prev_we, prev_addr, prev_wdata}))
          hs_ok = 1'b0;
        if (age == lat) begin
          ack = 1'b1; age = 0;
          if (exp_q.size() == 0) begin
            checkOutput("extra_beat", 1, 0);
          end else begin
            b = exp_q.pop_front();
            checkOutput("beat_we", s_we, b.we);
            checkOutput("beat_addr", s_addr, b.addr);
            if (b.we) checkOutput("beat_wdata", s_wdata, b.wdata);
            else begin rdata = rd_words[rd_n]; rd_n++; end
          end
        end else begin
          age++;
        end
      end
      if (s_fwe) begin
        nfill++; fill_cyc = n;
        checkOutput("fill_cycle", 128'(n), 128'(exp_fill));
        checkOutput("fill_way", fill_way_o, way);
        checkOutput("fill_addr", fill_addr_o, addr[ADDR_W-1:4]);
        checkOutput("fill_data", fill_data_o, exp_line);
      end
      if (s_done) begin
        done_cyc = n;
        checkOutput("done_cycle", 128'(n), 128'(fill_cyc + 1));
        checkOutput("done_stall", s_stall, 0);
        checkOutput("done_req", s_req, 0);
      end else if (!s_stall) begin
        stall_ok = 1'b0;
      end
      prev_req = s_req; prev_ack = ack; prev_we = s_we; prev_addr = s_addr; prev_wdata = s_wdata;
      mem_bus.mem_ack_i = ack; mem_bus.mem_rdata_i = rdata;
      @(posedge clk_i);
    end
    if (done_cyc < 0) checkOutput("timeout", 0, 1);
    checkOutput("beats_left", 128'(exp_q.size()), 0);
    checkOutput("fill_count", 128'(nfill), 1);
    checkOutput("handshake", hs_ok, 1);
    checkOutput("stall_held", stall_ok, 1);
  endtask

  task automatic missKilled();
    bit quiet = 1'b1;
    @(negedge clk_i);
    c_miss_i = 1'b1; kill_i = 1'b1; c_addr_i = 20'h3C3C0;
    #1 checkOutput("kill_stall", stall_core_o, 0);
    repeat (3) begin
      @(negedge clk_i);
      if (mem_bus.mem_req_o || fill_we_o || refill_done_o || stall_core_o) quiet = 1'b0;
    end
    checkOutput("kill_noreq", quiet, 1);
    c_miss_i = 1'b0; kill_i = 1'b0;
  endtask

  task automatic resetMidFill();
    int  acks = 0;
    int  age = 0;
    bit  reached = 1'b0;
    logic ack;
    @(negedge clk_i);
    c_miss_i = 1'b1; kill_i = 1'b0; c_addr_i = 20'h5A5A0; c_lru_way_i = 2'd1; victim_dirty_i = 1'b0;
    @(posedge clk_i);
    for (int n = 0; n < 40 && !reached; n++) begin
      @(negedge clk_i);
      c_miss_i = 1'b0; ack = 1'b0;
      if (mem_bus.mem_req_o) begin
        if (acks == 2) reached = 1'b1;
        else if (age == 1) begin ack = 1'b1; age = 0; acks++; end
        else age++;
      end
      mem_bus.mem_ack_i = ack; mem_bus.mem_rdata_i = $urandom;
      if (!reached) @(posedge clk_i);
    end
    checkOutput("reach_beat2", reached, 1);
    rsn_i = 1'b0;
    #1;
    checkOutput("rst_ctrl", {mem_bus.mem_req_o, mem_bus.mem_we_o, fill_we_o, refill_done_o, stall_core_o}, 0);
    checkOutput("rst_bus", {mem_bus.mem_addr_o, mem_bus.mem_wdata_o, fill_way_o, fill_addr_o}, 0);
    checkOutput("rst_data", fill_data_o, 0);
    @(negedge clk_i);
    rsn_i = 1'b1;
  endtask

  initial begin
    mem_bus.mem_ack_i = 1'b0; mem_bus.mem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    checkOutput("reset_state", {mem_bus.mem_req_o, mem_bus.mem_we_o, fill_we_o, refill_done_o, stall_core_o}, 0);
    rsn_i = 1'b1;
    applyStimulus(20'h12340, 2'd2, 1'b0, 16'h0000, 128'h0, 0, 0, 1'b0);
    applyStimulus(20'h55550, 2'd1, 1'b1, 16'h0ABC,
                  128'h33333333_22222222_11111111_00000000, 3, 0, 1'b0);
    missKilled();
    applyStimulus(20'h2F0F0, 2'd3, 1'b0, 16'h0000, 128'h0, 1, 5, 1'b0);
    resetMidFill();
    applyStimulus(20'h0BEE0, 2'd0, 1'b0, 16'h0000, 128'h0, 0, 0, 1'b0);
    applyStimulus(20'h77770, 2'd2, 1'b0, 16'h0000, 128'h0, 2, 0, 1'b1);
    applyStimulus(20'h88880, 2'd1, 1'b0, 16'h0000, 128'h0, 0, 0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(ADDR_W'($urandom), WAY_W'($urandom), 1'($urandom), LINE_ADDR_W'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk_i);
    c_miss_i = 1'b0; kill_i = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no end of run, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Data-cache miss controller for the Vi core's C (cache) stage. It sits after the TL→C pipeline latch, takes the latched miss, victim way and address, and sequences the refill. With writeback compiled in, it first writes back a dirty victim line to memory. Each line moves as 32-bit beats over a req/ack memory port. The block drives the core-wide stall, and writes the refilled line into the selected way of the data/tag arrays.

## Interface
- ADDR_W, 20, byte address width (matches TL/C stage address)
- LINE_W, 128, cache line width in bits; beats per line BEATS = LINE_W/32 (4)
- WAY_W, 2, way-select width
---
- clk_i  in  1  clock
- rsn_i  in  1  reset, asynchronous, active-low
- c_miss_i  in  1  latched miss from C stage
- c_addr_i  in  ADDR_W  latched request byte address
- c_lru_way_i  in  WAY_W  latched victim way
- kill_i  in  1  flush of the C stage
- victim_dirty_i  in  1  dirty bit of victim line (sampled at miss accept)
- victim_addr_i  in  ADDR_W-4  victim line address (tag+index)
- victim_data_i  in  LINE_W  victim line data
- mem_req_o  out  1  memory beat request
- mem_we_o  out  1  1 = write beat, 0 = read beat
- mem_addr_o  out  ADDR_W  beat byte address, low 2 bits 0
- mem_wdata_o  out  32  write beat data
- mem_ack_i  in  1  beat accepted; read data valid same cycle
- mem_rdata_i  in  32  read beat data
- fill_we_o  out  1  write line into arrays (one-cycle pulse)
- fill_way_o  out  WAY_W  way to write
- fill_addr_o  out  ADDR_W-4  line address written (tag+index)
- fill_data_o  out  LINE_W  refilled line
- refill_done_o  out  1  one-cycle pulse; C stage completes access from fill_data_o
- stall_core_o  out  1  freeze all pipeline latches

## Operation
- States: IDLE, WB, FILL, WRITE, DONE. Reset (async) → IDLE. All registered outputs are 0 and the beat counter is 0.
- IDLE: accept when c_miss_i && !kill_i. Capture c_addr_i[ADDR_W-1:4], c_lru_way_i, victim_dirty_i, victim_addr_i and victim_data_i. Go to WB if victim dirty, else FILL.
- WB: one write beat per handshake. mem_addr_o = {victim_addr, beat, 2'b00} and mem_wdata_o = victim_data[32*beat +: 32]. After ack of the last beat (beat==BEATS-1): counter→0, go to FILL.
- FILL: read beats at {line_addr, beat, 2'b00}. mem_rdata_i is stored into line buffer slot beat on ack. After the last ack, go to WRITE.
- WRITE: fill_we_o=1 with captured way/line address and assembled line; go to DONE.
- DONE: refill_done_o=1 and stall_core_o=0. c_miss_i is ignored this cycle (the latch still shows the old miss). Return to IDLE.
- Handshake: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are registered and stable from assertion until the cycle mem_ack_i=1. The next beat's request is presented the cycle after ack, so there is at least one idle cycle of mem_req_o between beats.
- kill_i outside IDLE is ignored: the transaction and the array write complete; refill_done_o still pulses (C stage discards it).
- stall_core_o = (state ∈ {WB,FILL,WRITE}) | (state==IDLE & c_miss_i & !kill_i). It is combinational, so the latch freezes in the detect cycle.
- Beat counter: log2(BEATS) bits and wraps to 0 after the last beat.

## Timing
- Miss seen in IDLE at edge t → mem_req_o=1 from t+1.
- Clean miss with per-beat ack latency of L cycles after req (L≥0; ack may arrive in the same cycle as req):
  - fill_we_o occurs at 1 + BEATS·(L+2) − 1 cycles after t.
  - refill_done_o occurs one cycle after fill_we_o.
- Dirty miss: add BEATS·(L+2) cycles before the first read request.
- Async reset mid-transaction: immediate return to IDLE; mem_req_o, fill_we_o and stall_core_o drop to 0 without waiting for ack.

## Configuration
- DCACHE_WB_EN defined: WB state present; dirty victims are written back before the fill.
- Undefined: the cache is write-through. victim_dirty_i, victim_addr_i and victim_data_i are unused, the WB state is removed, mem_we_o is tied 0, and every miss goes IDLE→FILL.

## Structure
- Shared package vi_dcache_pkg holds:
  - the state enum;
  - constants LINE_W, BEATS, BEAT_W=32, OFFSET_W=4.
- Sub-module dcache_line_buffer: LINE_W register with per-beat write enable (beat index + data). It drives fill_data_o and holds the captured victim line for WB beat selection.

## Test plan
- Clean miss, addr 0x12340, way 2, ack at L=0:
  - four read beats at 0x12340, 0x12344, 0x12348, 0x1234C;
  - then fill_we_o with way 2, fill_data_o = {d3,d2,d1,d0};
  - refill_done_o next cycle; stall_core_o low in the DONE cycle.
- Dirty miss, victim 0x0ABC, L=3:
  - four write beats at 0xABC0–0xABCC carrying victim words 0..3;
  - then four reads;
  - stall_core_o held high throughout.
- c_miss_i and kill_i high together in IDLE → no request, stall_core_o=0.
- kill_i during FILL → all beats and fill_we_o still occur, refill_done_o pulses.
- rsn_i low during beat 2 of FILL → next cycle all outputs 0 and state IDLE. A new miss restarts at beat 0.
- c_miss_i held high through DONE → no second refill in DONE. A fresh miss in the following IDLE cycle is accepted.
